// File: rtl/dma_read_engine_pkg.sv
// Shared memory-system definitions: bank-target encodings, lane count and
// the read-engine state type.
package dma_read_engine_pkg;

   localparam int LANE_CNT   = 16;
   localparam int LANE_CNT_W = $clog2(LANE_CNT);

   typedef enum logic [1:0] {
      TGT_RAM_A  = 2'd0,
      TGT_RAM_B  = 2'd1,
      TGT_WEIGHT = 2'd2,
      TGT_CONST  = 2'd3
   } rd_target_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SEND,
      S_DONE
   } dma_state_e;

endpackage

// File: rtl/dma_read_engine_lane_serializer.sv
// lane_serializer: loads one wide memory word and hands it out one lane at a
// time, lane 0 (LSBs) first, over a valid/ready handshake.
module lane_serializer
   import dma_read_engine_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int LANE_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_data,
   output logic              last
);

   logic [DATA_W-1:0]     shreg_q, shreg_d;
   logic [LANE_CNT_W-1:0] lanes_left_q, lanes_left_d;
   logic                  valid_q, valid_d;
   logic                  hs;

   always_comb begin
      shreg_d      = shreg_q;
      lanes_left_d = lanes_left_q;
      valid_d      = valid_q;
      hs           = valid_q && out_ready;
      last         = hs && (lanes_left_q == '0);
      if (load) begin
         shreg_d      = load_data;
         lanes_left_d = LANE_CNT_W'(LANE_CNT - 1);
         valid_d      = 1'b1;
      end else if (hs) begin
         shreg_d      = shreg_q >> LANE_W;
         lanes_left_d = lanes_left_q - LANE_CNT_W'(1);
         if (lanes_left_q == '0) valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q      <= '0;
         lanes_left_q <= '0;
         valid_q      <= 1'b0;
      end else begin
         shreg_q      <= shreg_d;
         lanes_left_q <= lanes_left_d;
         valid_q      <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = shreg_q[LANE_W-1:0];

endmodule

// File: rtl/dma_read_engine.sv
// DMA read engine: reads len words from one bank and streams them out as
// 16-bit lanes. Optional running checksum with DMA_RD_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start; parameters latched on accept
// REQ    | one-cycle read strobe for the current word
// WAIT   | read data returns; loaded into the serializer
// SEND   | lanes handed out; after the last lane fetch next word or finish
// DONE   | one-cycle done pulse
module dma_read_engine
   import dma_read_engine_pkg::*;
#(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 256,
   parameter int LANE_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        rd_target,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       len,
   output logic              mem_rd_en,
   output logic [1:0]        mem_rd_target,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_data,
   output logic              busy,
   output logic              done
`ifdef DMA_RD_CHECKSUM_EN
   , output logic [31:0]     checksum
`endif
);

   dma_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       words_left_q, words_left_d;
   rd_target_e        target_q, target_d;
   logic              ser_load, ser_last;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      words_left_d = words_left_q;
      target_d     = target_q;
      ser_load     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               target_d     = rd_target_e'(rd_target);
               addr_d       = base_addr;
               words_left_d = len;
               state_d      = (len == 16'd0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            // Address advances as the strobe retires; width gives the wrap.
            addr_d       = addr_q + ADDR_W'(1);
            words_left_d = words_left_q - 16'd1;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            ser_load = 1'b1;
            state_d  = S_SEND;
         end
         S_SEND: begin
            if (ser_last) state_d = (words_left_q != 16'd0) ? S_REQ : S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         words_left_q <= '0;
         target_q     <= TGT_RAM_A;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         words_left_q <= words_left_d;
         target_q     <= target_d;
      end
   end

   assign mem_rd_en     = (state_q == S_REQ);
   assign mem_rd_addr   = addr_q;
   assign mem_rd_target = target_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);

   lane_serializer #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .load_data (mem_rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .last      (ser_last)
   );

`ifdef DMA_RD_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == S_IDLE && start)
         csum_d = '0;
      else if (out_valid && out_ready)
         csum_d = csum_q + {{(32-LANE_W){out_data[LANE_W-1]}}, out_data};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) csum_q <= '0;
      else        csum_q <= csum_d;
   end

   assign checksum = csum_q;
`endif

endmodule
